// File: rtl/stage_event_gen_pkg.sv
// Shared definitions for the stage-change request producer.
package stage_event_gen_pkg;

  // Stage codes understood by the stage controller
  localparam logic [3:0] STAGE_FIRST    = 4'h0;
  localparam logic [3:0] CAVE_STAGE     = 4'hb;
  localparam logic [3:0] STAGE_GAMEOVER = 4'hf;

  // Latched request kind
  typedef enum logic [2:0] {
    ReqNone,
    ReqNext,
    ReqBack,
    ReqCave,
    ReqOver
  } req_code_e;

  // Request producer FSM
  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitAck,
    StCooldown,
    StDead
  } state_e;

  // One bit per request line; at most one set at a time
  typedef struct packed {
    logic nextstage;
    logic backstage;
    logic cave;
    logic gameover;
  } req_pulse_t;

  // Map a request code onto its single output line
  function automatic req_pulse_t req_decode(input req_code_e code);
    req_pulse_t p;
    p = '0;
    case (code)
      ReqNext: p.nextstage = 1'b1;
      ReqBack: p.backstage = 1'b1;
      ReqCave: p.cave      = 1'b1;
      ReqOver: p.gameover  = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/stage_evt_cooldown.sv
// Frame-tick down-counter: load a count, decrement once per tick, flag the tick
// that consumes the last count. Usable for any per-frame rate limiting.
module stage_evt_cooldown #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over tick; the counter parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // The tick that takes the count from one to zero ends the period
  assign done = tick && !load && (cnt_q == Width'(1));

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_event_gen.sv
// Stage-change request producer. Samples position / HP / cave door once per
// frame, issues one registered request pulse, waits for the stage controller
// to change its stage value, then holds off for a number of frames.
// Optional vertical edge detection is enabled by defining STAGE_EVT_VERT_EN.
module stage_event_gen #(
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned EDGE_MARGIN     = 4,
  parameter logic [3:0]  LAST_STAGE      = 4'ha,
  parameter logic [3:0]  CAVE_STAGE      = stage_event_gen_pkg::CAVE_STAGE,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned ACK_TIMEOUT     = 64
`ifdef STAGE_EVT_VERT_EN
  ,
  parameter int unsigned SCREEN_H        = 480
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
`ifdef STAGE_EVT_VERT_EN
  input  logic [9:0] player_y,
`endif
  input  logic [7:0] player_hp,
  input  logic       cave_hit,
  input  logic [3:0] stage,
  output logic       nextstage,
  output logic       backstage,
  output logic       cave,
  output logic       gameover,
  output logic       busy,
  output logic       ack_err
);

  import stage_event_gen_pkg::*;

  localparam logic [9:0] RightEdge = 10'(SCREEN_W - EDGE_MARGIN);
  localparam logic [9:0] LeftEdge  = 10'(EDGE_MARGIN);
`ifdef STAGE_EVT_VERT_EN
  localparam logic [9:0] BottomEdge = 10'(SCREEN_H - EDGE_MARGIN);
`endif
  localparam logic [9:0] AckLast   = 10'(ACK_TIMEOUT - 1);
  localparam logic [7:0] CdFrames  = 8'(COOLDOWN_FRAMES);

  state_e     state_q, state_d;
  req_code_e  code_q, code_d;
  req_code_e  cand;
  logic [3:0] stage_q, stage_d;
  logic [9:0] ack_cnt_q, ack_cnt_d;
  logic       ack_err_q, ack_err_d;
  req_pulse_t pulse_q, pulse_d;
  logic       at_right, at_left;
  logic       cd_load, cd_tick, cd_done;

  // Pick the highest-priority request the current inputs qualify for
  always_comb begin
    at_right = (player_x >= RightEdge);
    at_left  = (player_x < LeftEdge);
`ifdef STAGE_EVT_VERT_EN
    at_right = at_right | (player_y >= BottomEdge);
    at_left  = at_left | (player_y < LeftEdge);
`endif
    cand = ReqNone;
    if (player_hp == 8'd0) begin
      cand = ReqOver;
    end else if (cave_hit && (stage != CAVE_STAGE)) begin
      cand = ReqCave;
    end else if (at_right && (stage < LAST_STAGE)) begin
      cand = ReqNext;
    end else if (at_left && (stage != STAGE_FIRST)) begin
      cand = ReqBack;
    end
  end

  // Next-state, request latch and acknowledge tracking
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    stage_d   = stage_q;
    ack_cnt_d = ack_cnt_q;
    ack_err_d = ack_err_q;
    pulse_d   = '0;
    cd_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_tick && (cand != ReqNone)) begin
          code_d  = cand;
          stage_d = stage;
          state_d = StReq;
        end
      end
      StReq: begin
        pulse_d   = req_decode(code_q);
        ack_cnt_d = '0;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        // An acknowledge in the final counted cycle still beats the timeout
        if (stage != stage_q) begin
          cd_load = 1'b1;
          state_d = (code_q == ReqOver) ? StDead : StCooldown;
        end else if (ack_cnt_q == AckLast) begin
          ack_err_d = 1'b1;
          cd_load   = 1'b1;
          state_d   = (code_q == ReqOver) ? StDead : StCooldown;
        end else begin
          ack_cnt_d = ack_cnt_q + 10'd1;
        end
      end
      StCooldown: begin
        if (cd_done) begin
          state_d = StIdle;
        end
      end
      StDead: begin
        state_d = StDead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Only ticks seen while already cooling down count; the acknowledge cycle's tick does not
  assign cd_tick = frame_tick && (state_q == StCooldown);

  stage_evt_cooldown #(
    .Width (8)
  ) u_cooldown (
    .clk      (clk),
    .rst      (rst),
    .load     (cd_load),
    .load_val (CdFrames),
    .tick     (cd_tick),
    .done     (cd_done)
  );

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      code_q    <= ReqNone;
      stage_q   <= '0;
      ack_cnt_q <= '0;
      ack_err_q <= 1'b0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      stage_q   <= stage_d;
      ack_cnt_q <= ack_cnt_d;
      ack_err_q <= ack_err_d;
      pulse_q   <= pulse_d;
    end
  end

  assign nextstage = pulse_q.nextstage;
  assign backstage = pulse_q.backstage;
  assign cave      = pulse_q.cave;
  assign gameover  = pulse_q.gameover;
  assign busy      = (state_q != StIdle);
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_stage_event_gen.sv
// Bench for stage_event_gen: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the request protocol.
module tb_stage_event_gen;

  localparam int CdFrames   = 8;
  localparam int AckTimeout = 64;
  localparam int PhIdle     = 0;
  localparam int PhIssue    = 1;
  localparam int PhWait     = 2;
  localparam int PhCool     = 3;
  localparam int PhDead     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] player_x = 10'd300;
`ifdef STAGE_EVT_VERT_EN
  logic [9:0] player_y = 10'd200;
`endif
  logic [7:0] player_hp = 8'd100;
  logic       cave_hit = 1'b0;
  logic [3:0] stage = 4'h0;
  logic       nextstage, backstage, cave, gameover, busy, ack_err;

  int checks = 0;
  int failures = 0;

  // Model state: pulse vector is {next, back, cave, over}
  int         m_phase = PhIdle;
  logic [3:0] m_req = 4'b0;
  logic [3:0] m_stage = 4'h0;
  logic [3:0] m_pulse = 4'b0;
  logic       m_err = 1'b0;
  int         m_wait = 0;
  int         m_ticks = 0;
  int         dead_cycles = 0;

  stage_event_gen dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .player_x   (player_x),
`ifdef STAGE_EVT_VERT_EN
    .player_y   (player_y),
`endif
    .player_hp  (player_hp),
    .cave_hit   (cave_hit),
    .stage      (stage),
    .nextstage  (nextstage),
    .backstage  (backstage),
    .cave       (cave),
    .gameover   (gameover),
    .busy       (busy),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Request the rules ask for right now, as a one-hot {next, back, cave, over}
  function automatic logic [3:0] model_request();
    int  x;
    bit  right, left;
    x = int'(player_x);
    right = (x >= 640 - 4);
    left  = (x < 4);
`ifdef STAGE_EVT_VERT_EN
    right = right || (int'(player_y) >= 480 - 4);
    left  = left || (int'(player_y) < 4);
`endif
    if (player_hp == 8'd0) return 4'b0001;
    if (cave_hit && (stage != 4'hb)) return 4'b0010;
    if (right && (int'(stage) < 10)) return 4'b1000;
    if (left && (stage != 4'h0)) return 4'b0100;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_phase = PhIdle;
    m_pulse = 4'b0;
    m_err   = 1'b0;
    m_wait  = 0;
    m_ticks = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_clock();
    logic [3:0] want;
    bit         finished;
    m_pulse  = 4'b0;
    finished = 1'b0;
    case (m_phase)
      PhIdle: begin
        if (frame_tick) begin
          want = model_request();
          if (want != 4'b0) begin
            m_req   = want;
            m_stage = stage;
            m_phase = PhIssue;
          end
        end
      end
      PhIssue: begin
        m_pulse = m_req;
        m_wait  = 0;
        m_phase = PhWait;
      end
      PhWait: begin
        if (stage != m_stage) begin
          finished = 1'b1;
        end else if (m_wait == AckTimeout - 1) begin
          m_err    = 1'b1;
          finished = 1'b1;
        end else begin
          m_wait++;
        end
        if (finished) begin
          m_ticks = CdFrames;
          m_phase = (m_req == 4'b0001) ? PhDead : PhCool;
        end
      end
      PhCool: begin
        if (frame_tick) begin
          m_ticks--;
          if (m_ticks == 0) m_phase = PhIdle;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    logic [3:0] pulses;
    @(posedge clk);
    if (rst) model_clock();
    @(negedge clk);
    pulses = {nextstage, backstage, cave, gameover};
    check("outs", {26'd0, pulses, busy, ack_err},
          {26'd0, m_pulse, 1'(m_phase != PhIdle), m_err});
    check("onehot0", 32'($countones(pulses) <= 1), 32'd1);
  endtask

  task automatic tick(input int gap);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Right-edge crossing, acknowledge, cooldown, second crossing
    stage = 4'h2;
    player_x = 10'd637;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("s1_lat1", 32'(nextstage), 32'd0);
    step();
    check("s1_pulse", 32'(nextstage), 32'd1);
    step();
    check("s1_width", 32'(nextstage), 32'd0);
    stage = 4'h3;
    step();
    for (int i = 1; i <= CdFrames; i++) begin
      tick(2);
      check("s1_busy", 32'(busy), (i < CdFrames) ? 32'd1 : 32'd0);
    end
    tick(1);
    check("s1_second", 32'(nextstage), 32'd1);
    stage = 4'h4;
    step();
    repeat (CdFrames) tick(1);
    check("s1_idle", 32'(busy), 32'd0);

    // All conditions at once: gameover wins, then DEAD is terminal
    player_hp = 8'd0;
    cave_hit = 1'b1;
    player_x = 10'd639;
    stage = 4'h2;
    tick(1);
    check("s2_over", {28'd0, nextstage, backstage, cave, gameover}, 32'h1);
    stage = 4'hf;
    repeat (20) tick(1);
    check("s2_dead", {28'd0, nextstage, backstage, cave, gameover, busy}, 32'h1);
    do_reset();
    player_hp = 8'd100;
    cave_hit = 1'b0;

    // Stage guards block each candidate
    stage = 4'h0; player_x = 10'd1;
    tick(3);
    check("g_back", {26'd0, nextstage, backstage, cave, gameover, busy, ack_err}, 32'd0);
    stage = 4'ha; player_x = 10'd639;
    tick(3);
    check("g_next", {26'd0, nextstage, backstage, cave, gameover, busy, ack_err}, 32'd0);
    stage = 4'hb; player_x = 10'd300; cave_hit = 1'b1;
    tick(3);
    check("g_cave", {26'd0, nextstage, backstage, cave, gameover, busy, ack_err}, 32'd0);
    cave_hit = 1'b0;

    // Acknowledge timeout
    stage = 4'h5; player_x = 10'd2;
    tick(1);
    check("t_pulse", 32'(backstage), 32'd1);
    player_x = 10'd300;
    repeat (AckTimeout - 1) step();
    check("t_early", 32'(ack_err), 32'd0);
    step();
    check("t_err", 32'(ack_err), 32'd1);
    repeat (CdFrames) tick(1);
    check("t_sticky", {30'd0, busy, ack_err}, 32'd1);

    // Reset in the middle of cooldown
    do_reset();
    stage = 4'h2; player_x = 10'd637;
    tick(1);
    stage = 4'h3;
    step();
    repeat (3) tick(1);
    check("r_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("r_async", {26'd0, nextstage, backstage, cave, gameover, busy, ack_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    check("r_fresh", 32'(nextstage), 32'd1);
    stage = 4'h4;
    step();
    repeat (CdFrames) tick(1);

    // Bottom edge only counts with the vertical option
    player_x = 10'd300; stage = 4'h1;
`ifdef STAGE_EVT_VERT_EN
    player_y = 10'd478;
`endif
    tick(1);
`ifdef STAGE_EVT_VERT_EN
    check("v_next", 32'(nextstage), 32'd1);
    player_y = 10'd200;
`else
    check("v_next", 32'(nextstage), 32'd0);
`endif
    stage = 4'h2;
    step();
    repeat (CdFrames) tick(1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0: player_x = 10'($urandom_range(0, 5));
        1: player_x = 10'($urandom_range(634, 640));
        2: player_x = 10'($urandom_range(641, 1023));
        default: player_x = 10'($urandom_range(6, 633));
      endcase
`ifdef STAGE_EVT_VERT_EN
      player_y = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 1023))
                                              : 10'($urandom_range(4, 475));
`endif
      player_hp = ($urandom_range(0, 24) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      cave_hit = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) stage = 4'($urandom_range(0, 15));
      dead_cycles = (m_phase == PhDead) ? dead_cycles + 1 : 0;
      if ((dead_cycles > 25) || ($urandom_range(0, 599) == 0)) begin
        dead_cycles = 0;
        do_reset();
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_event_gen.md
Name: stage_event_gen

Overview:
- Producer side of the stage-change request interface.
- Watches player position, HP and the cave-door collision once per frame, then issues single-cycle request pulses (nextstage / backstage / cave / gameover) to the stage controller.
- Waits for the controller to acknowledge by changing its stage value, then applies a frame-based cooldown so that a single edge crossing produces exactly one request.

Parameters:
- SCREEN_W, 640, horizontal pixel count.
- EDGE_MARGIN, 4, px from the left/right edge that counts as a crossing.
- LAST_STAGE, 4'ha, highest overworld stage; no nextstage is issued at or above it.
- CAVE_STAGE, 4'hb, cave stage code; no cave request is issued while in it.
- COOLDOWN_FRAMES, 8, frame_ticks ignored after an acknowledge (1..255).
- ACK_TIMEOUT, 64, clk cycles to wait for the stage to change (1..1023).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- player_x  in  10  player left x, px
- player_hp  in  8  player hit points
- cave_hit  in  1  player overlaps cave door (level signal)
- stage  in  4  current stage from the stage controller
- nextstage  out  1  request pulse
- backstage  out  1  request pulse
- cave  out  1  request pulse
- gameover  out  1  request pulse
- busy  out  1  high in any state except IDLE
- ack_err  out  1  sticky; set on acknowledge timeout

Behaviour:
- One clock domain; rst is asynchronous, active-low. Reset forces state IDLE, all pulse outputs 0, busy 0, ack_err 0, counters 0.
- Request outputs are registered and form a onehot0 group: at most one is high in any cycle, and each is high for exactly one cycle.
- FSM states: IDLE, REQ, WAIT_ACK, COOLDOWN, DEAD.
- IDLE: evaluates conditions only on a cycle with frame_tick=1. Candidates, in priority order:
  1. gameover: player_hp==0.
  2. cave: cave_hit && stage!=CAVE_STAGE.
  3. nextstage: player_x >= SCREEN_W-EDGE_MARGIN && stage<LAST_STAGE.
  4. backstage: player_x < EDGE_MARGIN && stage!=0.
  - If any candidate holds: latch its code, latch stage into stage_q, go to REQ. Otherwise stay in IDLE.
- REQ: the latched pulse is high for this cycle only; go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - If stage!=stage_q: go to DEAD when the latched code was gameover, otherwise go to COOLDOWN.
  - If the counter reaches ACK_TIMEOUT-1 first: set ack_err, then go to COOLDOWN (or DEAD for gameover).
  - The request is never re-issued.
- COOLDOWN: counts frame_ticks. On the COOLDOWN_FRAMES-th tick, return to IDLE. That tick is not evaluated; the first evaluation happens on the next tick.
- DEAD: terminal; all pulses stay 0 and busy=1. Only rst exits this state.
- Input conditions that change while not in IDLE are ignored, not queued.
- A frame_tick in the same cycle as the acknowledge does not count toward cooldown.
- Comparisons are unsigned. SCREEN_W-EDGE_MARGIN is a 10-bit constant, so player_x values beyond the screen still count as right-edge crossings.
- Reset asserted mid-REQ truncates nothing, because the pulse is already registered; the FSM returns to IDLE asynchronously.

Optional Feature:
- Macro: STAGE_EVT_VERT_EN.
- When defined:
  - Adds input player_y[9:0] and parameter SCREEN_H=480.
  - player_y >= SCREEN_H-EDGE_MARGIN is also a nextstage candidate.
  - player_y < EDGE_MARGIN is also a backstage candidate.
  - Same priority rank and stage guards as the horizontal checks.
- When undefined: port and parameter are absent; horizontal edges only.

Decomposition:
- Shared package holds:
  - Stage code constants: STAGE_FIRST=4'h0, CAVE_STAGE=4'hb, STAGE_GAMEOVER=4'hf.
  - Request-code enum: REQ_NONE, REQ_NEXT, REQ_BACK, REQ_CAVE, REQ_OVER.
  - FSM state encoding.
- One natural sub-module, stage_evt_cooldown: a frame_tick down-counter with load/done, reused for other per-frame rate limiting.

Test Plan:
- Right-edge crossing: rst released, stage=2, player_x=637, frame_tick pulse.
  - nextstage high for exactly 1 cycle, 2 cycles after the tick.
  - Drive stage=3 three cycles later: busy stays high through 8 more ticks, then drops.
  - A further tick with player_x=637 and stage=3 produces a second nextstage.
- Simultaneous conditions: hp=0, cave_hit=1, player_x=639, stage=2, one tick.
  - Only gameover pulses.
  - After stage=4'hf, the block enters DEAD: no pulses over 20 more ticks, busy=1.
- Guards: stage=0 with player_x=1 gives no backstage; stage=4'ha with player_x=639 gives no nextstage; stage=4'hb with cave_hit=1 gives no cave.
  - Required response in all three: all outputs 0, busy=0.
- Acknowledge timeout: backstage issued with stage held at 5.
  - ack_err=1 exactly 64 cycles after the pulse.
  - Cooldown follows; ack_err stays 1 until rst.
- Reset mid-operation: assert rst while in COOLDOWN with 3 ticks counted.
  - All outputs immediately 0, with no clock edge needed.
  - After release, the first qualifying tick issues a request with no cooldown.
- STAGE_EVT_VERT_EN defined: player_y=478, player_x=300, stage=1, one tick -> nextstage pulse.
  - Same case with the macro undefined -> no pulse.
